// File: rtl/sub_16bits_pipe.sv
// Two-stage pipelined 16-bit subtractor (x - y - b_in) behind a valid/ready handshake.
// Optional: define SUB_SAT_EN to clamp signed overflow to 16'h7FFF / 16'h8000.

module sub_cla_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_c,
    output logic [W-1:0] o_sum,
    output logic         o_c
);
    // Each carry is a flat OR of generate terms gated by propagate products (look-ahead, no ripple chain).
    always_comb begin
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W:0]   c;
        logic         acc;
        logic         prod;
        g    = i_a & i_b;
        p    = i_a ^ i_b;
        c    = '0;
        c[0] = i_c;
        acc  = 1'b0;
        prod = 1'b0;
        for (int i = 0; i < W; i++) begin
            acc  = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = acc | (prod & i_c);
        end
        o_sum = p ^ c[W-1:0];
        o_c   = c[W];
    end
endmodule

module sub_16bits_pipe #(
    parameter int LO_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        b_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] d,
    output logic        b_out,
    output logic        ovf
);
    localparam int HI_W = 16 - LO_W;

    logic [2:1]      r_vld_pipe;
    logic [LO_W-1:0] r_s1_dlo;
    logic            r_s1_bor;
    logic [HI_W-1:0] r_s1_xhi;
    logic [HI_W-1:0] r_s1_yhi;

    logic            w_s1_adv;
    logic            w_s2_adv;
    logic            w_s1_load;
    logic            w_s2_load;
    logic [LO_W-1:0] w_lo_sum;
    logic            w_lo_c;
    logic [HI_W-1:0] w_hi_sum;
    logic            w_hi_c;
    logic [15:0]     w_d_wrap;
    logic [15:0]     w_d_res;
    logic            w_ovf;
    logic            w_x15;

    assign w_s2_adv  = !r_vld_pipe[2] || out_ready;
    assign w_s1_adv  = !r_vld_pipe[1] || w_s2_adv;
    assign w_s1_load = in_valid && w_s1_adv;
    assign w_s2_load = r_vld_pipe[1] && w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_vld_pipe[2];

    // Subtraction as x + ~y + ~b_in; carry and borrow are complements of each other.
    sub_cla_slice #(.W(LO_W)) u_lo (
        .i_a   (x[LO_W-1:0]),
        .i_b   (~y[LO_W-1:0]),
        .i_c   (~b_in),
        .o_sum (w_lo_sum),
        .o_c   (w_lo_c)
    );

    sub_cla_slice #(.W(HI_W)) u_hi (
        .i_a   (r_s1_xhi),
        .i_b   (~r_s1_yhi),
        .i_c   (~r_s1_bor),
        .o_sum (w_hi_sum),
        .o_c   (w_hi_c)
    );

    assign w_x15    = r_s1_xhi[HI_W-1];
    assign w_d_wrap = {w_hi_sum, r_s1_dlo};
    assign w_ovf    = (w_x15 != r_s1_yhi[HI_W-1]) && (w_d_wrap[15] != w_x15);

`ifdef SUB_SAT_EN
    assign w_d_res = w_ovf ? (w_x15 ? 16'h8000 : 16'h7FFF) : w_d_wrap;
`else
    assign w_d_res = w_d_wrap;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_s1_dlo   <= '0;
            r_s1_bor   <= 1'b0;
            r_s1_xhi   <= '0;
            r_s1_yhi   <= '0;
            d          <= '0;
            b_out      <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (w_s1_adv)
                r_vld_pipe[1] <= in_valid;
            if (w_s1_load) begin
                r_s1_dlo <= w_lo_sum;
                r_s1_bor <= ~w_lo_c;
                r_s1_xhi <= x[15:LO_W];
                r_s1_yhi <= y[15:LO_W];
            end
            if (w_s2_adv)
                r_vld_pipe[2] <= r_vld_pipe[1];
            if (w_s2_load) begin
                d     <= w_d_res;
                b_out <= ~w_hi_c;
                ovf   <= w_ovf;
            end
        end
    end
endmodule

// File: tb/tb_sub_16bits_pipe.sv
// Directed and randomized checks for sub_16bits_pipe (LO_W=8).
module tb_sub_16bits_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        b_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] d;
    logic        b_out;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    sub_16bits_pipe #(.LO_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .b_out     (b_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: 17-bit subtraction, then signed overflow and optional clamp.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        logic [16:0] full;
        logic [15:0] r;
        logic        o;
        full = {1'b0, a} - {1'b0, b} - {16'h0, bi};
        r    = full[15:0];
        o    = (a[15] != b[15]) && (r[15] != a[15]);
`ifdef SUB_SAT_EN
        if (o) r = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {full[16], o, r};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_d got %h want 0000", d); end
        checks++; if (b_out !== 1'b0) begin errors++; $display("FAIL reset_b_out got %b want 0", b_out); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        x = 16'h1234; y = 16'h0034; b_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
        checks++; if (d !== 16'h1200) begin errors++; $display("FAIL basic_d got %h want 1200", d); end
        checks++; if ({b_out, ovf} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b want 00", {b_out, ovf}); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b want 0", out_valid); end
    endtask

    task automatic test_boundary();
        x = 16'h0100; y = 16'h0001; b_in = 1'b0; in_valid = 1'b1;
        tick();
        x = 16'h0000; y = 16'h0000; b_in = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, d} !== {1'b1, 16'h00FF}) begin errors++; $display("FAIL slice_borrow_d got %b/%h want 1/00ff", out_valid, d); end
        checks++; if ({b_out, ovf} !== 2'b00) begin errors++; $display("FAIL slice_borrow_flags got %b want 00", {b_out, ovf}); end
        tick();
        checks++; if ({out_valid, d} !== {1'b1, 16'hFFFF}) begin errors++; $display("FAIL borrow_in_d got %b/%h want 1/ffff", out_valid, d); end
        checks++; if ({b_out, ovf} !== 2'b10) begin errors++; $display("FAIL borrow_in_flags got %b want 10", {b_out, ovf}); end
        tick();
    endtask

    task automatic test_overflow();
        logic [15:0] exp_d;
`ifdef SUB_SAT_EN
        exp_d = 16'h8000;
`else
        exp_d = 16'h7FFF;
`endif
        x = 16'h8000; y = 16'h0001; b_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if ({out_valid, d} !== {1'b1, exp_d}) begin errors++; $display("FAIL ovf_d got %b/%h want 1/%h", out_valid, d, exp_d); end
        checks++; if ({b_out, ovf} !== 2'b01) begin errors++; $display("FAIL ovf_flags got %b want 01", {b_out, ovf}); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        x = 16'd1; y = 16'd1; b_in = 1'b0; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %b want 1", in_ready); end
        tick();
        x = 16'd5; y = 16'd2;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
        tick();
        x = 16'd9; y = 16'd4;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b want 0", in_ready); end
        tick(); tick();
        checks++; if ({out_valid, d} !== {1'b1, 16'd0}) begin errors++; $display("FAIL bp_hold got %b/%h want 1/0000", out_valid, d); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full got %b want 0", in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, d} !== {1'b1, 16'd3}) begin errors++; $display("FAIL bp_second got %b/%h want 1/0003", out_valid, d); end
        tick();
        checks++; if ({out_valid, d} !== {1'b1, 16'd5}) begin errors++; $display("FAIL bp_third got %b/%h want 1/0005", out_valid, d); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        x = 16'h4444; y = 16'h1111; b_in = 1'b0; in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if ({out_valid, d} !== {1'b0, 16'h0}) begin errors++; $display("FAIL rmid_flush got %b/%h want 0/0000", out_valid, d); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", in_ready); end
        x = 16'h0010; y = 16'h0001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_ghost got %b want 0", out_valid); end
        tick();
        checks++; if ({out_valid, d} !== {1'b1, 16'h000F}) begin errors++; $display("FAIL rmid_first got %b/%h want 1/000f", out_valid, d); end
        tick();
    endtask

    task automatic test_random();
        logic [17:0] q[$];
        logic [17:0] exp;
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        bit acc;
        while ((sent < 64 || recv < 64) && cyc < 3000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 64 && ($urandom_range(0, 4) != 0)) begin
                x = 16'($urandom); y = 16'($urandom); b_in = 1'($urandom);
                in_valid = 1'b1;
            end
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
                checks++;
                if ({b_out, ovf, d} !== exp) begin
                    errors++;
                    $display("FAIL rand_beat%0d got b%b o%b d%h want b%b o%b d%h", recv, b_out, ovf, d, exp[17], exp[16], exp[15:0]);
                end
                recv++;
            end
            if (acc) begin
                q.push_back(model(x, y, b_in));
                sent++;
            end
            tick();
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (recv != 64) begin errors++; $display("FAIL rand_count got %0d want 64", recv); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
